trivium_stream: RTL

- Parametrised Trivium keystream generator built around the 288-bit state register.
- Loads an 80-bit key and an 80-bit IV, then runs the 1152-round warm-up.
- After warm-up, delivers keystream W bits per handshake over a valid/ready interface.
- Generalises the single-round state update to W unrolled rounds per clock, adding key/IV load, a warm-up counter, and output flow control.

---
 rtl/trivium_pkg.sv | 38 +++
 rtl/trivium_stream_if.sv | 24 ++
 rtl/trivium_round.sv | 23 ++
 rtl/trivium_stream.sv | 118 +++++++++++
 4 files changed

// File: rtl/trivium_pkg.sv
// Shared constants, tap positions and FSM state type for the Trivium keystream generator.
package trivium_pkg;

  localparam int unsigned STATE_W     = 288;
  localparam int unsigned KEY_W       = 80;
  localparam int unsigned IV_W        = 80;
  localparam int unsigned INIT_ROUNDS = 1152;

  // Taps are zero-based indices into s[287:0]; s[0] is the newest bit of segment A.
  localparam int unsigned T1_A = 65;
  localparam int unsigned T1_B = 90;
  localparam int unsigned T1_C = 91;
  localparam int unsigned T1_D = 92;
  localparam int unsigned T1_E = 170;

  localparam int unsigned T2_A = 161;
  localparam int unsigned T2_B = 174;
  localparam int unsigned T2_C = 175;
  localparam int unsigned T2_D = 176;
  localparam int unsigned T2_E = 263;

  localparam int unsigned T3_A = 242;
  localparam int unsigned T3_B = 285;
  localparam int unsigned T3_C = 286;
  localparam int unsigned T3_D = 287;
  localparam int unsigned T3_E = 68;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN
  } state_t;

  function automatic bit legal_width(input int unsigned w);
    return (w inside {1, 2, 4, 8, 16, 32, 64}) && ((INIT_ROUNDS % w) == 0);
  endfunction

endpackage

// File: rtl/trivium_stream_if.sv
// Control and keystream handshake bundle between a consumer and trivium_stream.
interface trivium_stream_if #(
  parameter int unsigned W = 8
);

  logic                          START;
  logic [trivium_pkg::KEY_W-1:0] KEY;
  logic [trivium_pkg::IV_W-1:0]  IV;
  logic                          BUSY;
  logic                          KS_VALID;
  logic                          KS_READY;
  logic [W-1:0]                  KS;

  modport master (
    output START, KEY, IV, KS_READY,
    input  BUSY, KS_VALID, KS
  );

  modport slave (
    input  START, KEY, IV, KS_READY,
    output BUSY, KS_VALID, KS
  );

endinterface

// File: rtl/trivium_round.sv
// One combinational Trivium round: next state plus the keystream bit of the incoming state.
module trivium_round
  import trivium_pkg::*;
(
  input  logic [STATE_W-1:0] i_s,
  output logic [STATE_W-1:0] o_s,
  output logic               o_z
);

  logic w_t1;
  logic w_t2;
  logic w_t3;

  assign w_t1 = i_s[T1_A] ^ (i_s[T1_B] & i_s[T1_C]) ^ i_s[T1_D] ^ i_s[T1_E];
  assign w_t2 = i_s[T2_A] ^ (i_s[T2_B] & i_s[T2_C]) ^ i_s[T2_D] ^ i_s[T2_E];
  assign w_t3 = i_s[T3_A] ^ (i_s[T3_B] & i_s[T3_C]) ^ i_s[T3_D] ^ i_s[T3_E];

  assign o_z = i_s[T1_A] ^ i_s[T1_D] ^ i_s[T2_A] ^ i_s[T2_D] ^ i_s[T3_A] ^ i_s[T3_D];

  // Each segment shifts toward its high end; the feedback bit enters at the segment's low end.
  assign o_s = {i_s[286:177], w_t2, i_s[175:93], w_t1, i_s[91:0], w_t3};

endmodule

// File: rtl/trivium_stream.sv
// Trivium keystream generator: key/IV load, 1152-round warm-up, then W bits per handshake.
module trivium_stream
  import trivium_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  trivium_stream_if.slave   bus
);

  localparam int unsigned ADV   = INIT_ROUNDS / W;
  localparam int unsigned CNT_W = $clog2(ADV + 1);

  if (!legal_width(W)) begin : g_bad_w
    $error("trivium_stream: W must be one of 1,2,4,8,16,32,64");
  end

  state_t             r_state;
  state_t             w_next_state;
  logic [STATE_W-1:0] r_s;
  logic [CNT_W-1:0]   r_cnt;
  logic [STATE_W-1:0] w_load_val;
  logic [STATE_W-1:0] w_adv_s;
  logic [W-1:0]       w_z;
  logic               w_load;
  logic               w_advance;
  logic               w_busy;
  logic               w_valid;

  for (genvar g = 0; g < W; g++) begin : g_rnd
    logic [STATE_W-1:0] w_in;
    logic [STATE_W-1:0] w_out;
    if (g == 0) begin : g_first
      assign w_in = r_s;
    end else begin : g_link
      assign w_in = g_rnd[g-1].w_out;
    end
    trivium_round u_round (
      .i_s (w_in),
      .o_s (w_out),
      .o_z (w_z[g])
    );
  end

  assign w_adv_s    = g_rnd[W-1].w_out;
  assign w_load_val = {3'b111, 108'd0, 4'd0, bus.IV, 13'd0, bus.KEY};

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_advance    = 1'b0;
    w_busy       = 1'b0;
    w_valid      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.START) begin
          w_load       = 1'b1;
          w_next_state = ST_INIT;
        end
      end
      ST_INIT: begin
        w_busy = 1'b1;
        if (bus.START) begin
          w_load       = 1'b1;
          w_next_state = ST_INIT;
        end else begin
          w_advance = 1'b1;
          if (r_cnt == CNT_W'(ADV - 1)) w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        w_valid = 1'b1;
        // A restart wins over a same-cycle handshake; the pending word is dropped.
        if (bus.START) begin
          w_load       = 1'b1;
          w_next_state = ST_INIT;
        end else if (bus.KS_READY) begin
          w_advance = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_s <= '0;
    end else if (w_load) begin
      r_s <= w_load_val;
    end else if (w_advance) begin
      r_s <= w_adv_s;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= '0;
    end else if (w_advance && (r_state == ST_INIT)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.BUSY     = w_busy;
  assign bus.KS_VALID = w_valid;
  assign bus.KS       = w_z;

endmodule
